// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans NUM_DIGITS common-anode hex digits over one shared active-low segment bus.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to also darken leading zero digits above digit 0.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       hex_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         anode_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          scan_wrap
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD      = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    logic [PW-1:0]           presc;
    logic [4*NUM_DIGITS-1:0] shadow_hex;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              nibble;
    logic                    dark;
    logic                    guard;
    logic                    presc_wrap;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // a digit is dark when it and every more-significant nibble are zero
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (shadow_hex[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif
    assign nibble     = shadow_hex[4*digit_idx +: 4];
    assign dark       = shadow_blank[digit_idx] | lz_blank[digit_idx];
    assign guard      = presc < GUARD;
    assign presc_wrap = presc == PRESC_LAST;
    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            digit_idx    <= '0;
            shadow_hex   <= '0;
            shadow_blank <= '0;
            seg_out      <= '1;
            anode_out    <= '1;
            scan_wrap    <= 1'b0;
        end else begin
            presc     <= presc_wrap ? '0 : presc + PW'(1);
            digit_idx <= presc_wrap ? (digit_idx == DIGIT_LAST ? '0 : digit_idx + IW'(1)) : digit_idx;
            scan_wrap <= presc_wrap && digit_idx == DIGIT_LAST;
            if (load) begin
                shadow_hex   <= hex_in;
                shadow_blank <= blank_in;
            end
            anode_out <= guard ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
            seg_out   <= (guard || dark) ? 7'h7F : SEG_LUT[nibble];
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench for seven_seg_scan_driver with a cycle model and targeted display checks.
module tb_seven_seg_scan_driver;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int G   = 1;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       wrap;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg_out;
    logic [3:0]  anode_out;
    logic [1:0]  digit_idx;
    logic        scan_wrap;
    int checks = 0;
    int errors = 0;
    int wraps  = 0;
    int m_presc = 0;
    int m_idx   = 0;
    logic [15:0] m_hex   = '0;
    logic [3:0]  m_blank = '0;
    exp_t sb[$];
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .blank_in(blank_in),
        .seg_out(seg_out), .anode_out(anode_out), .digit_idx(digit_idx), .scan_wrap(scan_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic lead_zero(input int k);
        if (k == 0) return 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        for (int j = k; j < N; j++)
            if (m_hex[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // drive one cycle of stimulus, predict the registered outputs, then compare after the edge
    task automatic step(input logic ld, input logic [15:0] h, input logic [3:0] b, input logic rst);
        exp_t e;
        exp_t o;
        logic guard;
        logic wrap;
        reset = rst;
        load = ld;
        hex_in = h;
        blank_in = b;
        guard = m_presc < G;
        wrap = m_presc == DIV - 1;
        if (rst) begin
            e = '{seg: 7'h7F, an: 4'hF, idx: 2'd0, wrap: 1'b0};
            m_presc = 0;
            m_idx = 0;
            m_hex = '0;
            m_blank = '0;
        end else begin
            e.an   = guard ? 4'hF : ~(4'b0001 << m_idx);
            e.seg  = (guard || m_blank[m_idx] || lead_zero(m_idx)) ? 7'h7F : lut[m_hex[4*m_idx +: 4]];
            e.wrap = wrap && m_idx == N - 1;
            m_idx  = wrap ? (m_idx + 1) % N : m_idx;
            e.idx  = 2'(m_idx);
            m_presc = wrap ? 0 : m_presc + 1;
            if (ld) begin
                m_hex = h;
                m_blank = b;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("sb_seg", 32'(seg_out), 32'(o.seg));
        check("sb_anode", 32'(anode_out), 32'(o.an));
        check("sb_idx", 32'(digit_idx), 32'(o.idx));
        check("sb_wrap", 32'(scan_wrap), 32'(o.wrap));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 4'hF, 1'b1);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_anode", 32'(anode_out), 32'hF);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_wrap", 32'(scan_wrap), 32'h0);

        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) begin
                step(p == 0 && c == 0, 16'h1234, 4'h0, 1'b0);
                wraps += int'(scan_wrap);
                check("scan_anode", 32'(anode_out), c == 0 ? 32'hF : 32'(scan_an[p]));
                if (c != 0) check("scan_seg", 32'(seg_out), 32'(scan_seg[p]));
            end
        check("wrap_count", 32'(wraps), 32'd1);

        for (int x = 0; x < 16; x++) begin
            step(1'b1, {4{4'(x)}}, 4'h0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step(1'b0, {4{4'(x)}}, 4'h0, 1'b0);
                if (anode_out != 4'hF && !(LZ && x == 0)) check("decode", 32'(seg_out), 32'(lut[x]));
            end
        end

        step(1'b1, 16'h8888, 4'b0100, 1'b0);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 16'h8888, 4'b0100, 1'b0);
            if (anode_out == 4'b1011) check("blank_d2", 32'(seg_out), 32'h7F);
            else if (anode_out != 4'hF) check("unblank", 32'(seg_out), 32'h00);
        end
        for (int i = 0; i < 20 && !(m_idx == 1 && m_presc == 2); i++) step(1'b0, 16'h8888, 4'b0100, 1'b0);
        check("pre_load_anode", 32'(anode_out), 32'b1101);
        check("pre_load_seg", 32'(seg_out), 32'h00);
        step(1'b1, 16'h0000, 4'h0, 1'b0);
        check("load_edge_anode", 32'(anode_out), 32'b1101);
        check("load_edge_seg", 32'(seg_out), 32'h00);
        step(1'b0, 16'h0000, 4'h0, 1'b0);
        check("mid_load_anode", 32'(anode_out), 32'b1101);
        check("mid_load_seg", 32'(seg_out), LZ ? 32'h7F : 32'h40);

        step(1'b1, 16'h5678, 4'h0, 1'b0);
        for (int i = 0; i < 20 && m_idx != 2; i++) step(1'b0, 16'h5678, 4'h0, 1'b0);
        step(1'b1, 16'hFFFF, 4'h0, 1'b1);
        check("mid_rst_seg", 32'(seg_out), 32'h7F);
        check("mid_rst_anode", 32'(anode_out), 32'hF);
        check("mid_rst_idx", 32'(digit_idx), 32'h0);
        check("mid_rst_wrap", 32'(scan_wrap), 32'h0);
        step(1'b0, 16'hFFFF, 4'h0, 1'b0);
        check("post_rst_guard", 32'(anode_out), 32'hF);
        step(1'b0, 16'hFFFF, 4'h0, 1'b0);
        check("post_rst_anode", 32'(anode_out), 32'b1110);
        check("post_rst_seg", 32'(seg_out), 32'h40);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        step(1'b1, 16'h0050, 4'h0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 16'h0050, 4'h0, 1'b0);
            if (anode_out != 4'hF)
                check("lz_0050", 32'(seg_out),
                      anode_out == 4'b1101 ? 32'h12 : anode_out == 4'b1110 ? 32'h40 : 32'h7F);
        end
        step(1'b1, 16'h0000, 4'h0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 16'h0000, 4'h0, 1'b0);
            if (anode_out != 4'hF)
                check("lz_0000", 32'(seg_out), anode_out == 4'b1110 ? 32'h40 : 32'h7F);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Latches a packed hex word on a load strobe, then cycles through the digits, enabling one anode at a time and driving its decoded segment pattern.
- Sits between the arithmetic/result logic and the board display pins; it is the parametrised, scanned successor of the team's single-digit hex-to-segment decoder.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Legal range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit stays selected. Minimum 4.
- GUARD_CYCLES, 1: cycles with all anodes off at each digit change (anti-ghosting). Legal range 0..REFRESH_DIV-2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: when high, hex_in and blank_in are captured into shadow registers on this edge.
- hex_in, input, 4*NUM_DIGITS: packed nibbles; digit k uses bits [4k+3:4k]; digit 0 is least significant (rightmost).
- blank_in, input, NUM_DIGITS: bit k=1 forces digit k dark.
- seg_out, output, 7: segments {g,f,e,d,c,b,a}, bit6=g, active-low.
- anode_out, output, NUM_DIGITS: digit enables, active-low, one-hot-cold.
- digit_idx, output, clog2(NUM_DIGITS): index of the digit currently being scanned.
- scan_wrap, output, 1: one-cycle pulse when the scan returns from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset values:
  - Prescaler, digit_idx, shadow hex and shadow blank all 0.
  - seg_out=7'b1111111, anode_out all 1s, scan_wrap=0.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0.
  - At a wrap, digit_idx increments modulo NUM_DIGITS.
  - digit_idx wraps NUM_DIGITS-1 -> 0; scan_wrap pulses high on that same cycle only.
- Guard window: while prescaler < GUARD_CYCLES, anode_out is all 1s and seg_out is all 1s.
- Drive window: for the rest of the period, anode_out bit digit_idx=0, all other bits 1, and seg_out = decode(shadow nibble[digit_idx]).
- Outputs are registered: anode_out and seg_out reflect the prescaler/digit_idx state of the previous cycle (1-cycle latency).
- Decode table, hex result, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Blanking: if shadow blank bit for digit_idx is 1, seg_out=7'h7F. The anode is still driven, so the scan timing is unchanged.
- Load:
  - Shadow update takes effect on the edge where load=1.
  - The new value appears on the next registered output cycle, including mid-period for the digit currently being driven.
  - load held high means continuous capture.
- Load and prescaler wrap on the same cycle: both take effect. The new digit shows the newly loaded nibble.
- Reset mid-scan: returns to the reset state on the next edge and overrides load. The first digit-0 drive window starts after GUARD_CYCLES.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k>=1) is additionally blanked when its nibble and all more-significant nibbles are 0. Digit 0 is never blanked by this rule, so a value of 0 shows a single "0". The rule is evaluated combinationally from the shadow register and ORed with blank_in.
- Undefined: only blank_in causes blanking; leading zeros are displayed.

Test Plan:
- Reset: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1; assert reset 3 cycles -> seg_out=7F, anode_out=4'b1111, digit_idx=0, scan_wrap=0.
- Scan order: load hex_in=16'h1234, blank_in=0 -> sequence per 4-cycle period:
  - digit0: anode 1110, seg 19;
  - digit1: anode 1101, seg 30;
  - digit2: anode 1011, seg 24;
  - digit3: anode 0111, seg 79;
  - each period has 1 guard cycle with anode 1111; scan_wrap pulses once per 16 cycles.
- Full decode: load each value 16'hXXXX for X=0..F -> every digit shows the table value (e.g. A=08, F=0E).
- Blank and mid-period load: load 16'h8888 with blank_in=4'b0100 -> digit2 seg=7F while its anode is low. Then load 16'h0000 during the digit1 drive window -> seg changes from 00 to 40 one cycle later, with no extra guard cycle.
- Reset mid-operation: assert reset while digit_idx=2 together with load=1, hex_in=16'hFFFF -> shadow stays 0, digit_idx=0, outputs at reset values.
- Macro (defined): load 16'h0050 -> digit3 and digit2 dark, digit1 seg=12, digit0 seg=40. Load 16'h0000 -> only digit0 lit, showing 40.
